vga_timing_gen: RTL

- Parametrised successor to the fixed 640x480@60 sync controller.
- Generates HS/VS/blank/data-enable plus frame and line strobes for any VESA-style mode.
- Runs from a system clock with a pixel-rate clock enable.
- Provides a configurable output-alignment delay so sync lines up with a pipelined pixel path. Sits between the clock/reset block and the frame-buffer readout / pixel renderer.

---
 rtl/vga_timing_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VESA-style sync generator.
// It advances on a pixel-rate enable. The timing outputs pass through a
// PIPE-stage alignment delay so that they line up with a pipelined pixel path.
// Optional raster line interrupt (irq_line / line_irq): define VGA_TIMING_LINE_IRQ_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned H_POL    = 0,
  parameter int unsigned V_POL    = 0,
  parameter int unsigned CW       = 11,
  parameter int unsigned PIPE     = 1
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic          en,
`ifdef VGA_TIMING_LINE_IRQ_EN
  input  logic [CW-1:0] irq_line,
  output logic          line_irq,
`endif
  output logic [CW-1:0] hcounter,
  output logic [CW-1:0] vcounter,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          de,
  output logic          frame_start,
  output logic          line_start
);

  localparam int unsigned HTOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic        HS_ON    = 1'(H_POL);
  localparam logic        VS_ON    = 1'(V_POL);

  // Elaboration-time legality checks on the mode parameters
  if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_timing_gen: active, porch and sync widths must all be >= 1");
  end
  if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE must be in 1..4");
  end
  if ($clog2(HTOTAL) > CW || $clog2(VTOTAL) > CW) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for HTOTAL/VTOTAL");
  end
  if (H_POL > 1 || V_POL > 1) begin : g_bad_pol
    $error("vga_timing_gen: H_POL/V_POL must be 0 or 1");
  end

  // One delay-line entry. Sync levels are stored already polarity-applied.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic de;
    logic fs;
    logic ls;
`ifdef VGA_TIMING_LINE_IRQ_EN
    logic irq;
`endif
  } stage_t;

  function automatic stage_t idle_stage();
    stage_t s;
    s       = '0;
    s.hs    = ~HS_ON;
    s.vs    = ~VS_ON;
    s.blank = 1'b1;
    return s;
  endfunction

  logic [CW-1:0]          hcnt_q, hcnt_d;
  logic [CW-1:0]          vcnt_q, vcnt_d;
  logic                   h_last, v_last;
  logic                   hsync_act, vsync_act, act;
  stage_t                 dec;
  stage_t [PIPE-1:0]      pipe_q, pipe_d;

  // Raster counter next state: h wraps at HTOTAL-1, v advances on h wrap
  always_comb begin
    h_last = (hcnt_q == CW'(HTOTAL - 1));
    v_last = (vcnt_q == CW'(VTOTAL - 1));
    hcnt_d = h_last ? '0 : hcnt_q + CW'(1);
    vcnt_d = vcnt_q;
    if (h_last) begin
      vcnt_d = v_last ? '0 : vcnt_q + CW'(1);
    end
  end

  // Raster counter registers; reset overrides the enable
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (en) begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Decode the current counter position into one delay-line entry
  always_comb begin
    hsync_act = (hcnt_q >= CW'(HS_START)) && (hcnt_q < CW'(HS_END));
    vsync_act = (vcnt_q >= CW'(VS_START)) && (vcnt_q < CW'(VS_END));
    act       = (hcnt_q < CW'(H_ACTIVE)) && (vcnt_q < CW'(V_ACTIVE));
    dec       = '0;
    dec.hs    = hsync_act ~^ HS_ON;
    dec.vs    = vsync_act ~^ VS_ON;
    dec.blank = ~act;
    dec.de    = act;
    dec.fs    = (hcnt_q == '0) && (vcnt_q == '0);
    dec.ls    = (hcnt_q == '0);
`ifdef VGA_TIMING_LINE_IRQ_EN
    dec.irq   = (hcnt_q == '0) && (vcnt_q == irq_line);
`endif
  end

  // Delay-line next state: shift on en, otherwise hold levels and drop strobes
  always_comb begin
    pipe_d = pipe_q;
    if (en) begin
      pipe_d[0] = dec;
      for (int i = 1; i < PIPE; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end else begin
      pipe_d[PIPE-1].fs  = 1'b0;
      pipe_d[PIPE-1].ls  = 1'b0;
`ifdef VGA_TIMING_LINE_IRQ_EN
      pipe_d[PIPE-1].irq = 1'b0;
`endif
    end
  end

  // Delay-line registers; the last stage is the registered output stage
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      pipe_q <= {PIPE{idle_stage()}};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign hcounter    = hcnt_q;
  assign vcounter    = vcnt_q;
  assign hs          = pipe_q[PIPE-1].hs;
  assign vs          = pipe_q[PIPE-1].vs;
  assign blank       = pipe_q[PIPE-1].blank;
  assign de          = pipe_q[PIPE-1].de;
  assign frame_start = pipe_q[PIPE-1].fs;
  assign line_start  = pipe_q[PIPE-1].ls;
`ifdef VGA_TIMING_LINE_IRQ_EN
  assign line_irq    = pipe_q[PIPE-1].irq;
`endif

endmodule
